// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and default sizes for the posted-write store buffer.
//   sb_state_e  - bus FSM state (idle, draining a write, fetching a load)
//   sb_entry_t  - one queued store at the default widths: word address + data
//   SB_DEPTH/SB_AW/SB_DW - default queue depth, address width, data width
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic [SB_AW-3:0] waddr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: handshake data-bus bundle between the store buffer and memory.
//   bus_req/bus_we/bus_addr/bus_wdata - request side, driven by the master
//   bus_ack/bus_rdata                 - one-cycle completion pulse and read data, from the slave
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int unsigned AW = SB_AW,
    parameter int unsigned DW = SB_DW
);
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/sb_fifo.sv
// sb_fifo: circular store queue with head/tail pointers and an occupancy count.
//   clk, reset           - clock, asynchronous active-low reset
//   i_push/i_push_waddr/i_push_data - enqueue at tail (ignored when full)
//   i_pop                - drop the head entry (ignored when empty)
//   o_count, o_head_ptr  - occupancy and index of the oldest entry
//   o_valid              - per-slot valid vector
//   o_waddr, o_data      - every slot's word address and data, for the forwarding compare
module sb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic [AW-3:0]                 i_push_waddr,
    input  logic [DW-1:0]                 i_push_data,
    input  logic                          i_pop,
    output logic [$clog2(DEPTH+1)-1:0]    o_count,
    output logic [$clog2(DEPTH)-1:0]      o_head_ptr,
    output logic [DEPTH-1:0]              o_valid,
    output logic [DEPTH-1:0][AW-3:0]      o_waddr,
    output logic [DEPTH-1:0][DW-1:0]      o_data
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]              r_head;
    logic [PW-1:0]              r_tail;
    logic [CW-1:0]              r_count;
    logic [DEPTH-1:0][AW-3:0]   r_waddr;
    logic [DEPTH-1:0][DW-1:0]   r_data;
    logic                       w_do_push;
    logic                       w_do_pop;

    assign w_do_push = i_push & (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop & (r_count != '0);

    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + 1'b1;
            if (w_do_pop)  r_head <= r_head + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // Payload needs no reset; o_valid masks stale slots.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_waddr[r_tail] <= i_push_waddr;
            r_data[r_tail]  <= i_push_data;
        end
    end

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        o_valid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            o_valid[i] = CW'(PW'(i) - r_head) < r_count;
        end
    end

    assign o_count    = r_count;
    assign o_head_ptr = r_head;
    assign o_waddr    = r_waddr;
    assign o_data     = r_data;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the core data port and a handshake bus.
//   clk, reset              - clock, asynchronous active-low reset
//   mem_write/mem_read      - core store/load request this cycle
//   addr, write_data        - core byte address and store data
//   read_data, stall        - load data and freeze request to the core
//   bus (master modport)    - bus_req/bus_we/bus_addr/bus_wdata out, bus_ack/bus_rdata in
// Build option: define STORE_BUF_FWD_EN to forward loads from queued stores and let loads
// bypass older non-matching stores; otherwise every load waits for an empty, idle buffer.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mem_write,
    input  logic           mem_read,
    input  logic [AW-1:0]  addr,
    input  logic [DW-1:0]  write_data,
    output logic [DW-1:0]  read_data,
    output logic           stall,
    store_buffer_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [CW-1:0]             w_count;
    logic [PW-1:0]             w_head_ptr;
    logic [DEPTH-1:0]          w_valid;
    logic [DEPTH-1:0][AW-3:0]  w_waddr;
    logic [DEPTH-1:0][DW-1:0]  w_data;

    sb_state_e     r_state;
    sb_state_e     w_state_next;
    logic [AW-3:0] r_rd_waddr;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_hit;
    logic [DW-1:0] w_fwd_data;
    logic          w_rd_start;
    logic          w_stall;
    logic [DW-1:0] w_read_data;

    assign w_full  = (w_count == CW'(DEPTH));
    assign w_empty = (w_count == '0);
    // A full queue refuses the store even if the head pops at this same edge.
    assign w_push  = mem_write & ~w_full;
    assign w_pop   = (r_state == StWr) & bus.bus_ack;
    // A simultaneous store wins; the load is then ignored.
    assign w_load  = mem_read & ~mem_write;

    sb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_waddr (addr[AW-1:2]),
        .i_push_data  (write_data),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head_ptr   (w_head_ptr),
        .o_valid      (w_valid),
        .o_waddr      (w_waddr),
        .o_data       (w_data)
    );

`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0] w_fwd_idx;

    // Walk oldest to youngest so the last match, the youngest store, wins.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_fwd_idx  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_fwd_idx = w_head_ptr + PW'(k);
            if (w_valid[w_fwd_idx] && (w_waddr[w_fwd_idx] == addr[AW-1:2])) begin
                w_hit      = 1'b1;
                w_fwd_data = w_data[w_fwd_idx];
            end
        end
    end

    // A miss may overtake queued stores: they cannot alias the load address.
    assign w_rd_start = w_load & ~w_hit;
`else
    logic w_unused_fwd;

    assign w_hit        = 1'b0;
    assign w_fwd_data   = '0;
    assign w_unused_fwd = ^w_valid;
    // Without forwarding a load only goes to the bus once every store has drained.
    assign w_rd_start   = w_load & w_empty;
`endif

    // Read takes priority over draining; a store pushed this edge starts draining at once.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_rd_start)              w_state_next = StRd;
                else if (!w_empty || w_push) w_state_next = StWr;
            end
            StWr:    if (bus.bus_ack) w_state_next = StIdle;
            StRd:    if (bus.bus_ack) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_rd_waddr <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && w_rd_start) r_rd_waddr <= addr[AW-1:2];
        end
    end

    // Head slot does not move until its ack, so address/data stay stable through WR.
    always_comb begin
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        unique case (r_state)
            StWr: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_addr  = {w_waddr[w_head_ptr], 2'b00};
                bus.bus_wdata = w_data[w_head_ptr];
            end
            StRd: begin
                bus.bus_req  = 1'b1;
                bus.bus_addr = {r_rd_waddr, 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_stall     = 1'b0;
        w_read_data = '0;
        if (mem_write) begin
            w_stall = w_full;
        end else if (mem_read) begin
            if (w_hit) begin
                w_read_data = w_fwd_data;
            end else if (r_state == StRd && bus.bus_ack) begin
                w_read_data = bus.bus_rdata;
            end else begin
                w_stall = 1'b1;
            end
        end
    end

    // Core-facing outputs are forced low while reset is held.
    assign stall     = w_stall & reset;
    assign read_data = w_read_data & {DW{reset}};
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer (DEPTH=4, AW=DW=32).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;

    int n_total;
    int n_bad;

    store_buffer_if #(.AW(32), .DW(32)) sbif ();

    store_buffer #(
        .DEPTH (4),
        .AW    (32),
        .DW    (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .bus        (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        addr       = '0;
        write_data = '0;
    endtask

    // Wait (bounded) for a bus write, check it, then ack it for one cycle.
    task automatic drain_one(input string tag, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (sbif.bus_req) seen = 1'b1;
        end
        check_eq({tag, " req"}, 64'(seen), 64'd1);
        check_eq({tag, " we"}, 64'(sbif.bus_we), 64'd1);
        check_eq({tag, " addr"}, 64'(sbif.bus_addr), 64'(exp_addr));
        check_eq({tag, " wdata"}, 64'(sbif.bus_wdata), 64'(exp_data));
        sbif.bus_ack = 1'b1;
        next_cyc();
        sbif.bus_ack = 1'b0;
    endtask

    // Wait (bounded) for a bus read, check the request, ack with data and check the core side.
    task automatic do_read(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] rdata);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (sbif.bus_req) seen = 1'b1;
        end
        check_eq({tag, " req"}, 64'(seen), 64'd1);
        check_eq({tag, " we"}, 64'(sbif.bus_we), 64'd0);
        check_eq({tag, " addr"}, 64'(sbif.bus_addr), 64'(exp_addr));
        check_eq({tag, " wdata"}, 64'(sbif.bus_wdata), 64'd0);
        check_eq({tag, " stall pre-ack"}, 64'(stall), 64'd1);
        sbif.bus_rdata = rdata;
        sbif.bus_ack   = 1'b1;
        #1;
        check_eq({tag, " stall ack"}, 64'(stall), 64'd0);
        check_eq({tag, " rdata"}, 64'(read_data), 64'(rdata));
        next_cyc();
        sbif.bus_ack   = 1'b0;
        sbif.bus_rdata = '0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b0;
        sbif.bus_ack   = 1'b0;
        sbif.bus_rdata = '0;
        drive_idle();

        // Reset state
        @(negedge clk);
        check_eq("rst bus_req", 64'(sbif.bus_req), 64'd0);
        check_eq("rst bus_addr", 64'(sbif.bus_addr), 64'd0);
        check_eq("rst stall", 64'(stall), 64'd0);
        check_eq("rst read_data", 64'(read_data), 64'd0);
        check_eq("rst count", 64'(dut.w_count), 64'd0);
        next_cyc();
        reset = 1'b1;
        next_cyc();

        // Single store, ack tied high
        mem_write  = 1'b1;
        addr       = 32'h100;
        write_data = 32'hAAAA_0001;
        sbif.bus_ack = 1'b1;
        @(negedge clk);
        check_eq("st1 stall", 64'(stall), 64'd0);
        check_eq("st1 req E0", 64'(sbif.bus_req), 64'd0);
        next_cyc();
        drive_idle();
        @(negedge clk);
        check_eq("st1 req", 64'(sbif.bus_req), 64'd1);
        check_eq("st1 we", 64'(sbif.bus_we), 64'd1);
        check_eq("st1 addr", 64'(sbif.bus_addr), 64'h100);
        check_eq("st1 wdata", 64'(sbif.bus_wdata), 64'hAAAA_0001);
        check_eq("st1 stall2", 64'(stall), 64'd0);
        next_cyc();
        @(negedge clk);
        check_eq("st1 popped", 64'(dut.w_count), 64'd0);
        check_eq("st1 idle", 64'(sbif.bus_req), 64'd0);
        sbif.bus_ack = 1'b0;
        next_cyc();

        // Five back-to-back stores against DEPTH=4, ack withheld
        for (int k = 0; k < 4; k++) begin
            mem_write  = 1'b1;
            addr       = 32'h10 + 32'(4 * k);
            write_data = 32'(k + 1);
            @(negedge clk);
            check_eq("fill stall", 64'(stall), 64'd0);
            next_cyc();
        end
        addr       = 32'h20;
        write_data = 32'd5;
        @(negedge clk);
        check_eq("full stall", 64'(stall), 64'd1);
        check_eq("full head addr", 64'(sbif.bus_addr), 64'h10);
        check_eq("full head data", 64'(sbif.bus_wdata), 64'd1);
        sbif.bus_ack = 1'b1;
        #1;
        check_eq("full stall on ack", 64'(stall), 64'd1);
        next_cyc();
        sbif.bus_ack = 1'b0;
        @(negedge clk);
        check_eq("full accept", 64'(stall), 64'd0);
        check_eq("full gap", 64'(sbif.bus_req), 64'd0);
        check_eq("full count", 64'(dut.w_count), 64'd3);
        next_cyc();
        drive_idle();
        drain_one("drain2", 32'h14, 32'd2);
        drain_one("drain3", 32'h18, 32'd3);
        drain_one("drain4", 32'h1C, 32'd4);
        drain_one("drain5", 32'h20, 32'd5);
        next_cyc();

        // Same-word stores then a load of that word
        mem_write  = 1'b1;
        addr       = 32'h200;
        write_data = 32'h11;
        next_cyc();
        write_data = 32'h22;
        next_cyc();
        mem_write  = 1'b0;
        mem_read   = 1'b1;
        addr       = 32'h203;
        @(negedge clk);
`ifdef STORE_BUF_FWD_EN
        check_eq("fwd data", 64'(read_data), 64'h22);
        check_eq("fwd stall", 64'(stall), 64'd0);
        next_cyc();
        drive_idle();
        drain_one("fwd drain a", 32'h200, 32'h11);
        drain_one("fwd drain b", 32'h200, 32'h22);
`else
        check_eq("nofwd stall", 64'(stall), 64'd1);
        check_eq("nofwd data", 64'(read_data), 64'd0);
        drain_one("nofwd drain a", 32'h200, 32'h11);
        drain_one("nofwd drain b", 32'h200, 32'h22);
        do_read("nofwd rd", 32'h200, 32'hCAFE_0123);
        drive_idle();
`endif
        next_cyc();

        // Load miss arriving during a write
        mem_write  = 1'b1;
        addr       = 32'h500;
        write_data = 32'h55;
        next_cyc();
        mem_write = 1'b0;
        mem_read  = 1'b1;
        addr      = 32'h300;
        @(negedge clk);
        check_eq("miss wr stall", 64'(stall), 64'd1);
        check_eq("miss wr we", 64'(sbif.bus_we), 64'd1);
        check_eq("miss wr addr", 64'(sbif.bus_addr), 64'h500);
        next_cyc();
        next_cyc();
        sbif.bus_ack = 1'b1;
        @(negedge clk);
        check_eq("miss wr ack stall", 64'(stall), 64'd1);
        next_cyc();
        sbif.bus_ack = 1'b0;
        @(negedge clk);
        check_eq("miss gap req", 64'(sbif.bus_req), 64'd0);
        check_eq("miss gap stall", 64'(stall), 64'd1);
        do_read("miss rd", 32'h300, 32'hDEAD_BEEF);
        drive_idle();
        next_cyc();

        // Illegal read+write: store wins
        mem_write  = 1'b1;
        mem_read   = 1'b1;
        addr       = 32'h400;
        write_data = 32'h44;
        @(negedge clk);
        check_eq("rw read_data", 64'(read_data), 64'd0);
        check_eq("rw stall", 64'(stall), 64'd0);
        next_cyc();
        drive_idle();
        drain_one("rw drain", 32'h400, 32'h44);
        @(negedge clk);
        check_eq("rw no read", 64'(sbif.bus_req), 64'd0);
        next_cyc();

        // Reset mid-transaction with two entries queued
        mem_write  = 1'b1;
        addr       = 32'h600;
        write_data = 32'h6;
        next_cyc();
        addr       = 32'h604;
        write_data = 32'h7;
        next_cyc();
        mem_write = 1'b0;
        mem_read  = 1'b1;
        addr      = 32'h700;
        @(negedge clk);
        check_eq("pre-rst req", 64'(sbif.bus_req), 64'd1);
        check_eq("pre-rst count", 64'(dut.w_count), 64'd2);
        #1;
        reset = 1'b0;
        #1;
        check_eq("mid-rst req", 64'(sbif.bus_req), 64'd0);
        check_eq("mid-rst we", 64'(sbif.bus_we), 64'd0);
        check_eq("mid-rst addr", 64'(sbif.bus_addr), 64'd0);
        check_eq("mid-rst wdata", 64'(sbif.bus_wdata), 64'd0);
        check_eq("mid-rst stall", 64'(stall), 64'd0);
        check_eq("mid-rst read_data", 64'(read_data), 64'd0);
        check_eq("mid-rst count", 64'(dut.w_count), 64'd0);
        next_cyc();
        drive_idle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post-rst quiet", 64'(sbif.bus_req), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle RISC-V core's data-memory port and a slower handshake data bus. Stores are queued and drained in order, so the core does not wait for write latency. Loads are forwarded from the youngest matching queued store, or fetched over the bus while the core is stalled. A new `stall` output to the core freezes PC and register write-back while asserted.

## Interface
Parameters:
- `DEPTH`, 4, queue entries (power of two, ≥2)
- `AW`, 32, address width
- `DW`, 32, data width (full-word accesses only)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `mem_write`  in  1  core store request (this cycle)
- `mem_read`  in  1  core load request (this cycle)
- `addr`  in  AW  core ALU_result, byte address
- `write_data`  in  DW  store data
- `read_data`  out  DW  load data to core
- `stall`  out  1  core must hold state this cycle
- `bus_req`  out  1  bus transaction request
- `bus_we`  out  1  1 = write, 0 = read
- `bus_addr`  out  AW  word-aligned bus address (`[1:0]` = 0)
- `bus_wdata`  out  DW  bus write data
- `bus_ack`  in  1  one-cycle completion pulse
- `bus_rdata`  in  DW  read data, valid with `bus_ack`

## Operation
- Entry = {addr[AW-1:2], data}. Circular queue: head/tail pointers plus count (0..DEPTH).
- Store: `mem_write & ~full` enqueues at the clock edge. `mem_write & full` → `stall`=1 and nothing is enqueued. This holds even if the head drains in the same cycle.
- `mem_read & mem_write` both high is illegal. The store takes precedence and `read_data`=0.
- Load hit: compare `addr[AW-1:2]` against all valid entries. The youngest match drives `read_data` combinationally, `stall`=0.
- Load miss: `stall`=1 until the bus read's ack cycle. In that cycle `read_data`=`bus_rdata` and `stall`=0.
- When no load is active, `read_data`=0.
- FSM states: IDLE, WR, RD.
  - IDLE→RD when a load misses. This has priority over draining.
  - IDLE→WR when count>0 and there is no load miss.
  - WR→IDLE on `bus_ack`, popping the head.
  - RD→IDLE on `bus_ack`.
- Bus signals:
  - `bus_req`=1 only in WR/RD. `bus_we`=1 in WR.
  - `bus_addr`/`bus_wdata` are held stable from request until ack.
  - One IDLE cycle separates consecutive transactions.
  - `bus_wdata`=0 in RD and IDLE. `bus_addr`=0 in IDLE.
- A load miss arriving during WR stalls until that write acks, then passes through IDLE to RD. Any remaining stores drain after the read.
- Loads bypass older non-matching stores. This is safe because they are address-disjoint.

## Timing
- Reset (async assert, sync release): queue empty, FSM IDLE. `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `read_data`, `stall` all 0.
- Reset mid-transaction drops `bus_req` immediately. Queued stores are discarded.
- Store accepted at edge E0 → `bus_req` high in the cycle after E0 (if IDLE). With an ack in that cycle, the entry pops at edge E1.
- Load hit: zero added latency.
- Load miss from IDLE: stall cycle (IDLE), then RD cycles until ack. Minimum 2 stall cycles, 1 of which is the ack cycle with `stall`=0.
- `stall` is combinational from `mem_write`, `mem_read`, address compare, FSM state and `bus_ack`.
- Full boundary: count==DEPTH blocks enqueue. Empty: count==0 keeps FSM in IDLE.
- Pointers wrap modulo DEPTH.
- A simultaneous enqueue and pop at the same edge leaves count unchanged.
- The head being drained remains forwardable until its ack edge.

## Configuration
- `STORE_BUF_FWD_EN` defined: load-hit forwarding and load-bypass as above.
- Undefined:
  - No address compare.
  - Any load with count>0 or FSM≠IDLE stalls until the queue is empty and the FSM is IDLE, then performs the bus read.
  - Loads never bypass stores.

## Structure
- Package `store_buffer_pkg`:
  - FSM state enum (IDLE/WR/RD)
  - default `DEPTH`/`AW`/`DW` constants
  - entry struct
- Sub-module `sb_fifo`: circular queue storage, pointers and count. Exports all entries plus a valid vector for the compare.
- FSM, forwarding priority and bus drive live in `store_buffer`.

## Test plan
- Reset with queue holding 2 entries and `bus_req`=1 → all outputs 0 immediately, count=0, no further bus activity.
- Store 0x100←0xAAAA_0001 with `bus_ack` tied high → `bus_req`/`bus_we`=1, `bus_addr`=0x100 the cycle after. Pop at the next edge. `stall` never 1.
- Five back-to-back stores with ack withheld (DEPTH=4) → fifth cycle `stall`=1. Accepted one cycle after the first ack and the IDLE gap. Drain order 1..5.
- Stores 0x200←0x11 then 0x200←0x22, then load 0x203, ack withheld → `read_data`=0x22, `stall`=0. Without `STORE_BUF_FWD_EN`: stall until both drain, then bus read.
- Load miss 0x300 during WR, ack after 3 cycles, `bus_rdata`=0xDEAD_BEEF → write acks, then IDLE cycle, then RD `bus_addr`=0x300. In the ack cycle `read_data`=0xDEAD_BEEF, `stall`=0.
- `mem_read`=`mem_write`=1 at 0x400 → store enqueued, `read_data`=0, no bus read.
